// File: rtl/fetch_unit.sv
// fetch_unit: credit-based fetch with 2-entry response FIFO; FETCH_STALL_CNT_EN adds stall_cnt
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_rd_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_insn
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  logic [31:0] fetch_pc, infl_pc, tgt;
  logic [31:0] f_pc [2];
  logic [31:0] f_insn [2];
  logic [1:0]  cnt, occ;
  logic        infl_v, rd_ptr, wr_ptr, fifo_ne, pop, pop_fifo, push, issue;
  assign tgt          = {redirect_pc[31:2], 2'b00};
  assign fifo_ne      = cnt != 2'd0;
  assign imem_rd_addr = rst ? RESET_PC : redirect_valid ? tgt : fetch_pc;
  assign out_valid    = !rst && !redirect_valid && (fifo_ne || infl_v);
  assign out_pc       = rst ? '0 : fifo_ne ? f_pc[rd_ptr] : infl_pc;
  assign out_insn     = rst ? '0 : fifo_ne ? f_insn[rd_ptr] : imem_rd_data;
  assign pop          = out_valid && out_ready;
  assign pop_fifo     = pop && fifo_ne;
  assign push         = infl_v && !redirect_valid && !(pop && !fifo_ne);
  assign occ          = cnt + {1'b0, infl_v} - {1'b0, pop};
  assign issue        = !rst && (redirect_valid || occ < 2'd2);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      infl_v   <= 1'b0;
      infl_pc  <= '0;
      cnt      <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      infl_v  <= issue;
      infl_pc <= imem_rd_addr;
      if (issue) fetch_pc <= imem_rd_addr + 32'd4;
      if (redirect_valid) begin
        cnt    <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        cnt <= cnt + {1'b0, push} - {1'b0, pop_fifo};
        if (push) wr_ptr <= !wr_ptr;
        if (pop_fifo) rd_ptr <= !rd_ptr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      f_pc[wr_ptr]   <= infl_pc;
      f_insn[wr_ptr] <= imem_rd_data;
    end
  end
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    stall_cnt <= rst ? '0 : stall_cnt + {31'd0, out_valid && !out_ready};
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random checks of fetch_unit against an in-order stream model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, rdy, rv;
  logic [31:0] rpc;
  logic [31:0] a_addr, a_data, a_pc, a_insn;
  logic        a_valid;
  logic [31:0] b_addr, b_data, b_pc, b_insn, b_rpc;
  logic        b_valid, b_rdy, b_rv;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] sc_a, sc_b;
`endif
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_pc, prev_pc, prev_insn, hold_addr;
  logic        prev_stall, prev_xfer, redir_last, rst_last;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) da (
    .clk(clk), .rst(rst), .imem_rd_addr(a_addr), .imem_rd_data(a_data),
    .redirect_valid(rv), .redirect_pc(rpc), .out_valid(a_valid), .out_ready(rdy),
    .out_pc(a_pc), .out_insn(a_insn)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(sc_a)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) db (
    .clk(clk), .rst(rst), .imem_rd_addr(b_addr), .imem_rd_data(b_data),
    .redirect_valid(b_rv), .redirect_pc(b_rpc), .out_valid(b_valid), .out_ready(b_rdy),
    .out_pc(b_pc), .out_insn(b_insn)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(sc_b)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    a_data <= mem(a_addr);
    b_data <= mem(b_addr);
  end

  task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected behaviour: an in-order address stream restarted by reset/redirect
  task automatic model();
    if (rst) begin
      ck("rst_valid", {31'd0, a_valid}, 32'd0);
      ck("rst_pc", a_pc, 32'd0);
      ck("rst_insn", a_insn, 32'd0);
      ck("rst_addr", a_addr, 32'd0);
      exp_pc = 32'd0; rst_last = 1'b1; redir_last = 1'b0; prev_stall = 1'b0; prev_xfer = 1'b0;
      return;
    end
    if (rv) ck("redir_kill", {31'd0, a_valid}, 32'd0);
    else if (redir_last) ck("restart_latency", {31'd0, a_valid}, 32'd1);
    if (rst_last && !rv) begin
      ck("first_issue_addr", a_addr, exp_pc);
      ck("first_issue_valid", {31'd0, a_valid}, 32'd0);
    end
    if (prev_stall && !rv) begin
      ck("hold_valid", {31'd0, a_valid}, 32'd1);
      ck("hold_pc", a_pc, prev_pc);
      ck("hold_insn", a_insn, prev_insn);
    end
    if (prev_xfer && rdy && !rv) ck("sustain", {31'd0, a_valid}, 32'd1);
    if (a_valid) begin
      ck("order_pc", a_pc, exp_pc);
      ck("order_insn", a_insn, mem(exp_pc));
    end
    prev_stall = a_valid && !rdy && !rv;
    prev_xfer  = a_valid && rdy && !rv;
    prev_pc    = a_pc;
    prev_insn  = a_insn;
    if (a_valid && rdy) exp_pc = exp_pc + 32'd4;
    if (rv) exp_pc = {rpc[31:2], 2'b00};
    redir_last = rv || rst_last;
    rst_last   = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    model();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rv = 1'b0; rpc = '0;
    b_rdy = 1'b1; b_rv = 1'b0; b_rpc = '0;
    exp_pc = '0; prev_pc = '0; prev_insn = '0; hold_addr = '0;
    prev_stall = 1'b0; prev_xfer = 1'b0; redir_last = 1'b0; rst_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      ck("b_rst_addr", b_addr, 32'hFFFF_FFF8);
      ck("b_rst_valid", {31'd0, b_valid}, 32'd0);
      adv();
    end
    rst = 1'b0;
    settle();
    ck("b_first_addr", b_addr, 32'hFFFF_FFF8);
    adv();
    for (int i = 0; i < 4; i++) begin
      settle();
      ck("stream_valid", {31'd0, a_valid}, 32'd1);
      ck("stream_pc", a_pc, 32'(4 * i));
      ck("b_wrap_valid", {31'd0, b_valid}, 32'd1);
      ck("b_wrap_pc", b_pc, 32'hFFFF_FFF8 + 32'(4 * i));
      ck("b_wrap_insn", b_insn, mem(32'hFFFF_FFF8 + 32'(4 * i)));
      adv();
    end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (i == 1) hold_addr = a_addr;
      if (i > 1) ck("stall_no_issue", a_addr, hold_addr);
      adv();
    end
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin settle(); adv(); end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin settle(); adv(); end
    rv = 1'b1; rpc = 32'h0000_0103;
    settle();
    ck("redir_addr", a_addr, 32'h0000_0100);
    ck("redir_valid", {31'd0, a_valid}, 32'd0);
    adv();
    rv = 1'b0; rdy = 1'b1;
    settle();
    ck("redir_target_pc", a_pc, 32'h0000_0100);
    adv();
    for (int i = 0; i < 2; i++) begin settle(); adv(); end
    rv = 1'b1; rpc = 32'h0000_0040;
    settle(); adv();
    rpc = 32'h0000_0080;
    settle(); adv();
    rv = 1'b0;
    settle();
    ck("b2b_target_pc", a_pc, 32'h0000_0080);
    ck("b2b_target_valid", {31'd0, a_valid}, 32'd1);
    adv();
    for (int i = 0; i < 3; i++) begin settle(); adv(); end
    rst = 1'b1;
    settle(); adv();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin settle(); adv(); end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin settle(); adv(); end
    rdy = 1'b1;
    settle();
`ifdef FETCH_STALL_CNT_EN
    ck("stall_cnt_3", sc_a, 32'd3);
`endif
    adv();
    rst = 1'b1;
    settle(); adv();
    settle();
`ifdef FETCH_STALL_CNT_EN
    ck("stall_cnt_rst", sc_a, 32'd0);
`endif
    adv();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rdy = $urandom_range(0, 3) != 0;
      rv  = $urandom_range(0, 11) == 0;
      rpc = $urandom;
      rst = $urandom_range(0, 79) == 0;
      settle();
      adv();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
